// File: rtl/beta_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// beta_dmem_arbiter
//
// Shares the single-ported Beta data memory between the CPU load/store port
// and a DMA/debug port. Each granted access is latched, the memory strobes
// are held for MEM_LAT cycles, read data is captured into the owner's rdata
// register, and a one-cycle ack is returned to the owner.
//
// The CPU has fixed priority. A starvation counter tracks consecutive CPU
// grants taken while the DMA port was also requesting; once it reaches
// STARVE_LIMIT the DMA port wins the next tie.
//
// Ports:
//   CLK, RESET        clock (rising edge), synchronous active-low reset
//   cpu_*             CPU request/payload in, rdata/ack/stall out
//   dma_*             DMA request/payload in, rdata/ack out
//   mem_*             data memory interface (MA, MWD, MWR, MOE, MRD)
//   busy              high while an access is in ACCESS or DONE
// ----------------------------------------------------------------------------
module beta_dmem_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESET,

    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,

    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        mem_oe,
    input  logic [31:0] mem_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t      state;
    logic        owner;        // 0 = CPU, 1 = DMA
    logic [3:0]  lat_cnt;
    logic [3:0]  starve_cnt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;

    // Saturating increment so a long CPU burst cannot wrap the counter
    // back below the limit and re-starve the DMA port.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic grant_any;
    logic grant_dma;
    logic sel_wr;

    assign grant_any = cpu_req | dma_req;
    assign grant_dma = dma_req & (~cpu_req | (starve_cnt >= STARVE_LIM));
    assign sel_wr    = grant_dma ? dma_wr : cpu_wr;

    // The memory address/data simply follow the latched payload, so they
    // hold their last value outside ACCESS.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            owner      <= 1'b0;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wr_q       <= 1'b0;
            cpu_rdata  <= 32'd0;
            dma_rdata  <= 32'd0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_oe     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                // ---- arbitration and payload latch ----
                IDLE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    if (grant_any) begin
                        owner   <= grant_dma;
                        addr_q  <= grant_dma ? dma_addr  : cpu_addr;
                        wdata_q <= grant_dma ? dma_wdata : cpu_wdata;
                        wr_q    <= sel_wr;
                        // Strobes are registered here so they are valid for
                        // the whole of the first ACCESS cycle.
                        mem_wr  <= sel_wr;
                        mem_oe  <= ~sel_wr;
                        busy    <= 1'b1;
                        lat_cnt <= LAT_INIT;
                        state   <= ACCESS;
                        if (grant_dma) begin
                            starve_cnt <= 4'd0;
                        end else if (dma_req) begin
                            starve_cnt <= sat_inc4(starve_cnt);
                        end
                    end
                end

                // ---- memory access, strobes held MEM_LAT cycles ----
                ACCESS: begin
                    if (lat_cnt == 4'd0) begin
                        if (!wr_q) begin
                            if (owner) begin
                                dma_rdata <= mem_rdata;
                            end else begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                        mem_wr  <= 1'b0;
                        mem_oe  <= 1'b0;
                        cpu_ack <= ~owner;
                        dma_ack <= owner;
                        state   <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                // ---- completion: ack visible for exactly this cycle ----
                DONE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    mem_wr  <= 1'b0;
                    mem_oe  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/beta_dmem_arbiter.md
Name: beta_dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the Beta single-ported data memory (MWR/MOE/MA/MWD/MRD). It shares the data memory between the CPU load/store port and a DMA/debug port. Each access is latched, the memory control strobes are driven for a fixed latency, read data is captured and a one-cycle acknowledge is returned. The CPU has fixed priority over the DMA port, with a starvation guard that guarantees the DMA port periodic service.

Parameters:
MEM_LAT, 1, memory access cycles per transaction (legal range 1..15)
STARVE_LIMIT, 4, consecutive CPU grants while dma_req is pending before the DMA port wins the next tie (legal range 1..15)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  synchronous reset, active-low (RESET=0 resets on the next CLK edge)
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_wr  in  1  1=store, 0=load
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU store data
cpu_rdata  out  32  CPU load data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_stall  out  1  cpu_req & ~cpu_ack; freezes the CPU PC
dma_req  in  1  DMA access request; held until dma_ack
dma_wr  in  1  1=write, 0=read
dma_addr  in  32  DMA byte address
dma_wdata  in  32  DMA write data
dma_rdata  out  32  DMA read data, valid while dma_ack=1
dma_ack  out  1  one-cycle completion pulse to DMA
mem_addr  out  32  to data memory MA
mem_wdata  out  32  to data memory MWD
mem_wr  out  1  to data memory MWR
mem_oe  out  1  to data memory MOE
mem_rdata  in  32  from data memory MRD
busy  out  1  high in ACCESS and DONE

Behaviour:
- States: IDLE, ACCESS, DONE. Registered: state, owner (0=CPU, 1=DMA), lat_cnt[3:0], starve_cnt[3:0], latched addr/wdata/wr, cpu_rdata, dma_rdata.
- Reset (RESET=0 at an edge): state=IDLE, lat_cnt=0, starve_cnt=0, both rdata registers=0, latched addr/wdata/wr=0. All outputs are 0 after reset.
- Reset mid-transaction aborts the transaction immediately: mem_wr/mem_oe drop, no ack is issued.
- IDLE, arbitration:
  - Only cpu_req: CPU wins.
  - Only dma_req: DMA wins.
  - Both: DMA wins if starve_cnt>=STARVE_LIMIT, otherwise CPU wins.
  - On a grant: latch the winner's addr/wdata/wr, set owner, lat_cnt=MEM_LAT-1, go to ACCESS.
  - CPU grant while dma_req=1: starve_cnt+1, saturating at 15.
  - Any DMA grant: starve_cnt=0.
  - CPU grant with dma_req=0: starve_cnt is unchanged.
- ACCESS:
  - mem_addr/mem_wdata come from the latched values. mem_wr=latched wr. mem_oe=~latched wr.
  - Strobes are held constant for MEM_LAT cycles.
  - lat_cnt decrements each cycle. At the edge where lat_cnt==0: for a read, capture mem_rdata into the owner's rdata register; then go to DONE.
- DONE:
  - owner's ack=1 for exactly this one cycle. mem_wr=mem_oe=0.
  - Go to IDLE on the next edge.
- Outside ACCESS, mem_addr/mem_wdata hold their last values.
- Latency: request sampled in IDLE at edge N → ack high in cycle N+MEM_LAT+1. Minimum repeat period is MEM_LAT+2 cycles.
- Requester protocol: hold req and payload until ack. Change them at the ack edge, either to a new request or to req=0. The following IDLE cycle samples the new value.
- Request inputs are ignored during ACCESS/DONE.
- If req drops mid-access, the access still completes and ack still pulses.
- Writes leave the rdata registers unchanged.
- rdata registers hold their value until the next read by the same owner.
- Never grant both ports at once. Acks are mutually exclusive.

Test Plan:
- Reset, then CPU read of addr 0x10 with mem_rdata=0xDEADBEEF, MEM_LAT=1 → mem_oe=1 for 1 cycle; cpu_ack in cycle 3 after req; cpu_rdata=0xDEADBEEF; cpu_stall high for 2 cycles.
- MEM_LAT=3, DMA write 0x1234 to 0x40 → mem_wr=1 with mem_addr=0x40 for 3 cycles; dma_ack one cycle later; dma_rdata stays 0.
- cpu_req and dma_req held continuously, STARVE_LIMIT=4 → grant order CPU,CPU,CPU,CPU,DMA,CPU,CPU,CPU,CPU,DMA; acks never overlap.
- RESET=0 asserted in the 2nd ACCESS cycle of a DMA write (MEM_LAT=3) → mem_wr=0 the next cycle; no dma_ack; starve_cnt=0; state IDLE.
- CPU read then CPU write back-to-back, req updated at the ack edge → second transaction granted in the IDLE cycle after DONE; period MEM_LAT+2 cycles.
- dma_req dropped in the middle of ACCESS → dma_ack still pulses once; no second access is started.
